// File: rtl/fetch_pkg.sv
// Shared widths, FSM encodings and entry layout for the instruction fetch queue.
package fetch_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // Flush outranks any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: request FSM, fetch PC and a decode-facing FIFO.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int unsigned     DEPTH    = 4,
   parameter  logic [XLEN-1:0] RESET_PC = 64'h0,
   localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_instr,
   input  logic            id_ready
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0] addr_nxt;
   logic [XLEN-1:0] redirect_al;
   logic [CW-1:0]   count, count_after;
   logic            push, pop;
   fetch_entry_t    head;

   assign redirect_al = {redirect_pc[XLEN-1:2], 2'b00};
   assign pop         = id_valid && id_ready;
   assign id_valid    = (count != '0);
   assign id_pc       = head.pc;
   assign id_instr    = head.instr;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ('{pc: imem_addr, instr: imem_rdata}),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Next state, next fetch PC and next request address.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      addr_nxt     = imem_addr;
      push         = 1'b0;
      count_after  = count;
      case (state)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redirect_al;
            end else if (count < CW'(DEPTH)) begin
               state_nxt = WAIT;
               addr_nxt  = fetch_pc;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redirect_al;
               state_nxt    = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               push         = 1'b1;
               fetch_pc_nxt = imem_addr + PC_INC;
               count_after  = count + CW'(1) - CW'(pop);
               if (count_after < CW'(DEPTH)) begin
                  addr_nxt = imem_addr + PC_INC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect_valid) begin
               fetch_pc_nxt = redirect_al;
            end
            if (imem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= {RESET_PC[XLEN-1:2], 2'b00};
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         state     <= state_nxt;
         fetch_pc  <= fetch_pc_nxt;
         imem_req  <= (state_nxt != IDLE);
         imem_addr <= addr_nxt;
      end
   end

endmodule
